swgbe_bframe_counter: RTL and testbench
=======================================

SWGBE_BFRAME_COUNTER -- requirements
Module: swgbe_bframe_counter

Interface
REQ-001 The block SHALL have parameter BAD_W, default 16, giving the bad-frame counter width.
REQ-002 The block SHALL have parameter RUNT_W, default 8, giving the runt-frame counter width.
REQ-003 The block SHALL have parameter MIN_WORDS, default 8, giving the minimum legal frame length in 64-bit words.
REQ-004 The block SHALL have port user_clk, input, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have port user_rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port rx_valid, input, 1 bit: 10GbE receive word valid.
REQ-007 The block SHALL have port rx_eof, input, 1 bit: last word of frame; qualified by rx_valid.
REQ-008 The block SHALL have port rx_bad, input, 1 bit: frame CRC/error flag; qualified by rx_valid & rx_eof.
REQ-009 The block SHALL have port rx_overrun, input, 1 bit: receive FIFO overrun pulse.
REQ-010 The block SHALL have port link_up, input, 1 bit: PHY link status level.
REQ-011 The block SHALL have port ctrl_clr, input, 1 bit: software clear level; acts on its rising edge.
REQ-012 The block SHALL have port status_data, output, 32 bits: packed status word; drives user_data_in of the OPB status register.

Function
REQ-013 Frame-tracking FSM SHALL have exactly two states, IDLE and IN_FRAME.
REQ-014 IDLE with rx_valid & !rx_eof SHALL go to IN_FRAME and set the word count to 1.
REQ-015 IN_FRAME with rx_valid SHALL increment the word count, saturating at MIN_WORDS.
REQ-016 IN_FRAME with rx_valid & rx_eof SHALL return to IDLE and close the frame.
REQ-017 rx_valid low SHALL hold the FSM state and word count.
REQ-018 IDLE with rx_valid & rx_eof SHALL close a one-word frame without leaving IDLE.
REQ-019 A closed frame SHALL be a runt when its length (including the eof word) is below MIN_WORDS.
REQ-020 A runt frame SHALL increment the runt counter.
REQ-021 A closed frame with rx_bad=1 SHALL increment the bad counter.
REQ-022 A frame that is both bad and runt SHALL increment both counters.
REQ-023 link_up=0 while IN_FRAME SHALL abort the frame: return to IDLE and increment the bad counter only.
REQ-024 rx_valid while link_up=0 SHALL be ignored.
REQ-025 Both counters SHALL saturate at all-ones and never wrap.
REQ-026 ctrl_clr SHALL be registered once in user_clk to form clr_pulse = ctrl_clr & !ctrl_clr_q.
REQ-027 clr_pulse SHALL zero both counters and both sticky bits.
REQ-028 clr_pulse SHALL NOT affect the FSM state.
REQ-029 clr_pulse coinciding with a counter increment SHALL leave that counter at 1.
REQ-030 clr_pulse coinciding with a sticky set SHALL leave that sticky bit at 1.
REQ-031 A bad frame closure or abort SHALL set bad_sticky; only clr_pulse or reset SHALL clear it.
REQ-032 An rx_overrun pulse SHALL set ovr_sticky; only clr_pulse or reset SHALL clear it.
REQ-033 status_data SHALL be registered with this packing: [31:16] bad count zero-extended to 16 bits; [15:8] runt count zero-extended to 8 bits; [7:4] 0; [3] bad_sticky; [2] ovr_sticky; [1] (state==IN_FRAME); [0] link_up.
REQ-034 status_data SHALL reflect an input event exactly 2 cycles after the event cycle: counter update, then output register.

Reset
REQ-035 user_rst SHALL set FSM=IDLE, word count=0, both counters=0, both sticky bits=0, ctrl_clr_q=1, status_data=32'h0.
REQ-036 ctrl_clr_q=1 at reset SHALL prevent a spurious clear when ctrl_clr is held high through reset.
REQ-037 user_rst asserted mid-frame SHALL discard the partial frame without counting it.
REQ-038 user_rst SHALL take priority over every other input.

Structure
REQ-039 A shared package SHALL hold the FSM state enum, the status bit-position constants, and the MIN_WORDS default.
REQ-040 One sub-module, swgbe_sat_counter (parameterised width, inc, clr, clear-plus-increment yields 1), SHALL be instantiated once for bad frames and once for runt frames.
REQ-041 The block SHALL contain no clock-domain crossings; the crossing to the OPB bus is handled by the downstream status register.

Verification
REQ-042 Clean 8-word frame with rx_bad=0 -> status_data=32'h0000_0001, with link_up=1.
REQ-043 3-word frame with rx_bad=1 -> status_data=32'h0001_0109 two cycles after eof.
REQ-044 70000 one-word bad frames -> bad field=16'hFFFF and runt field=8'hFF, with no wrap.
REQ-045 link_up drops on word 4 of a frame -> bad +1, runt unchanged, bit[1]=0, bit[0]=0.
REQ-046 ctrl_clr rising in the same cycle as a bad eof -> bad field=1, bad_sticky=1.
REQ-047 ctrl_clr held high for 10 cycles -> exactly one clear.
REQ-048 user_rst pulse mid-frame, then a 2-word frame -> status_data=32'h0000_0101.

Source files
------------

// File: rtl/swgbe_bframe_counter_pkg.sv
// Shared types and constants for the 10GbE bad/runt frame statistics block.
package swgbe_bframe_counter_pkg;

  // Frame-tracking states: waiting for a first word, or inside a multi-word frame
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } state_e;

  // Minimum legal frame length in 64-bit words
  localparam int MIN_WORDS_DEFAULT = 8;

  // Status word field positions
  localparam int STAT_BAD_MSB    = 31;
  localparam int STAT_BAD_LSB    = 16;
  localparam int STAT_RUNT_MSB   = 15;
  localparam int STAT_RUNT_LSB   = 8;
  localparam int STAT_BAD_STICKY = 3;
  localparam int STAT_OVR_STICKY = 2;
  localparam int STAT_IN_FRAME   = 1;
  localparam int STAT_LINK_UP    = 0;

endpackage

// File: rtl/swgbe_bframe_counter_sat.sv
// Saturating up-counter with synchronous clear; a clear in the same cycle as
// an increment leaves the count at 1 so the coinciding event is not lost.
module swgbe_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins over hold, increment stops at all-ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? W'(1) : '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/swgbe_bframe_counter.sv
// Counts bad and runt receive frames on the 10GbE user clock and packs the
// counts, sticky error flags and link/frame status into one status word.
module swgbe_bframe_counter
  import swgbe_bframe_counter_pkg::*;
#(
  parameter int BAD_W     = 16,
  parameter int RUNT_W    = 8,
  parameter int MIN_WORDS = MIN_WORDS_DEFAULT
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic        rx_valid,
  input  logic        rx_eof,
  input  logic        rx_bad,
  input  logic        rx_overrun,
  input  logic        link_up,
  input  logic        ctrl_clr,
  output logic [31:0] status_data
);

  localparam int CNT_W = $clog2(MIN_WORDS + 1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_WORDS);
  localparam logic [CNT_W:0]   MIN_LEN = (CNT_W + 1)'(MIN_WORDS);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [CNT_W:0]      frame_len;
  logic                ctrl_clr_q;
  logic                clr_pulse;
  logic                bad_inc, runt_inc;
  logic                bad_sticky_q, bad_sticky_d;
  logic                ovr_sticky_q, ovr_sticky_d;
  logic                link_q;
  logic [31:0]         status_q, status_d;
  logic [BAD_W-1:0]    bad_cnt;
  logic [RUNT_W-1:0]   runt_cnt;

  assign clr_pulse = ctrl_clr & ~ctrl_clr_q;
  assign frame_len = {1'b0, word_cnt_q} + (CNT_W + 1)'(1);

  // Frame tracking: word counting, frame closure and link-loss abort
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    bad_inc    = 1'b0;
    runt_inc   = 1'b0;
    if (!link_up) begin
      if (state_q == ST_IN_FRAME) begin
        state_d    = ST_IDLE;
        word_cnt_d = '0;
        bad_inc    = 1'b1;
      end
    end else if (rx_valid) begin
      if (state_q == ST_IDLE) begin
        if (rx_eof) begin
          bad_inc  = rx_bad;
          runt_inc = (MIN_WORDS > 1);
        end else begin
          state_d    = ST_IN_FRAME;
          word_cnt_d = CNT_W'(1);
        end
      end else begin
        if (rx_eof) begin
          state_d    = ST_IDLE;
          word_cnt_d = '0;
          bad_inc    = rx_bad;
          runt_inc   = (frame_len < MIN_LEN);
        end else if (word_cnt_q < MIN_CNT) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Sticky flags: a set in the same cycle as a clear survives the clear
  always_comb begin
    bad_sticky_d = clr_pulse ? bad_inc : (bad_sticky_q | bad_inc);
    ovr_sticky_d = clr_pulse ? rx_overrun : (ovr_sticky_q | rx_overrun);
  end

  swgbe_sat_counter #(.W(BAD_W)) u_bad_cnt (
    .clk   (user_clk),
    .rst   (user_rst),
    .inc   (bad_inc),
    .clr   (clr_pulse),
    .count (bad_cnt)
  );

  swgbe_sat_counter #(.W(RUNT_W)) u_runt_cnt (
    .clk   (user_clk),
    .rst   (user_rst),
    .inc   (runt_inc),
    .clr   (clr_pulse),
    .count (runt_cnt)
  );

  // Pack the already-registered state into the next status word
  always_comb begin
    status_d                                = '0;
    status_d[STAT_BAD_MSB:STAT_BAD_LSB]     = 16'(bad_cnt);
    status_d[STAT_RUNT_MSB:STAT_RUNT_LSB]   = 8'(runt_cnt);
    status_d[STAT_BAD_STICKY]               = bad_sticky_q;
    status_d[STAT_OVR_STICKY]               = ovr_sticky_q;
    status_d[STAT_IN_FRAME]                 = (state_q == ST_IN_FRAME);
    status_d[STAT_LINK_UP]                  = link_q;
  end

  // All block state; ctrl_clr_q resets high so a clear held through reset is not seen as an edge
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      ctrl_clr_q   <= 1'b1;
      bad_sticky_q <= 1'b0;
      ovr_sticky_q <= 1'b0;
      link_q       <= 1'b0;
      status_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      ctrl_clr_q   <= ctrl_clr;
      bad_sticky_q <= bad_sticky_d;
      ovr_sticky_q <= ovr_sticky_d;
      link_q       <= link_up;
      status_q     <= status_d;
    end
  end

  assign status_data = status_q;

endmodule

// File: tb/tb_swgbe_bframe_counter.sv
// Directed testbench for swgbe_bframe_counter with hand-computed status words.
module tb_swgbe_bframe_counter;

  logic        user_clk;
  logic        user_rst;
  logic        rx_valid;
  logic        rx_eof;
  logic        rx_bad;
  logic        rx_overrun;
  logic        link_up;
  logic        ctrl_clr;
  logic [31:0] status_data;

  int n_checks = 0;
  int n_fail   = 0;

  swgbe_bframe_counter dut (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .rx_valid    (rx_valid),
    .rx_eof      (rx_eof),
    .rx_bad      (rx_bad),
    .rx_overrun  (rx_overrun),
    .link_up     (link_up),
    .ctrl_clr    (ctrl_clr),
    .status_data (status_data)
  );

  // Free-running user clock
  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic cycle();
    @(posedge user_clk);
    #1;
  endtask

  task automatic apply_reset();
    user_rst   = 1'b1;
    rx_valid   = 1'b0;
    rx_eof     = 1'b0;
    rx_bad     = 1'b0;
    rx_overrun = 1'b0;
    link_up    = 1'b1;
    ctrl_clr   = 1'b0;
    cycle();
    cycle();
    user_rst = 1'b0;
  endtask

  // Drive a complete frame; returns right after the eof word has been clocked
  task automatic send_frame(input int len, input logic bad);
    for (int i = 0; i < len; i++) begin
      rx_valid = 1'b1;
      rx_eof   = (i == len - 1);
      rx_bad   = bad && (i == len - 1);
      cycle();
    end
    rx_valid = 1'b0;
    rx_eof   = 1'b0;
    rx_bad   = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (status_data !== 32'h0000_0000) begin
      n_fail++;
      $display("[TB] FAIL reset_value: got %h expected %h", status_data, 32'h0000_0000);
    end
    cycle();
    n_checks++;
    if (status_data !== 32'h0000_0000) begin
      n_fail++;
      $display("[TB] FAIL link_latency_1: got %h expected %h", status_data, 32'h0000_0000);
    end
    cycle();
    n_checks++;
    if (status_data !== 32'h0000_0001) begin
      n_fail++;
      $display("[TB] FAIL link_latency_2: got %h expected %h", status_data, 32'h0000_0001);
    end
  endtask

  task automatic test_clean_frame();
    apply_reset();
    send_frame(8, 1'b0);
    n_checks++;
    if (status_data !== 32'h0000_0003) begin
      n_fail++;
      $display("[TB] FAIL clean8_in_frame: got %h expected %h", status_data, 32'h0000_0003);
    end
    cycle();
    n_checks++;
    if (status_data !== 32'h0000_0001) begin
      n_fail++;
      $display("[TB] FAIL clean8_done: got %h expected %h", status_data, 32'h0000_0001);
    end
    send_frame(7, 1'b0);
    cycle();
    n_checks++;
    if (status_data !== 32'h0000_0101) begin
      n_fail++;
      $display("[TB] FAIL runt7: got %h expected %h", status_data, 32'h0000_0101);
    end
    send_frame(9, 1'b0);
    send_frame(20, 1'b0);
    cycle();
    n_checks++;
    if (status_data !== 32'h0000_0101) begin
      n_fail++;
      $display("[TB] FAIL long_frames: got %h expected %h", status_data, 32'h0000_0101);
    end
  endtask

  task automatic test_bad_runt();
    apply_reset();
    send_frame(3, 1'b1);
    n_checks++;
    if (status_data !== 32'h0000_0003) begin
      n_fail++;
      $display("[TB] FAIL bad3_latency: got %h expected %h", status_data, 32'h0000_0003);
    end
    cycle();
    n_checks++;
    if (status_data !== 32'h0001_0109) begin
      n_fail++;
      $display("[TB] FAIL bad3_runt: got %h expected %h", status_data, 32'h0001_0109);
    end
    send_frame(8, 1'b1);
    cycle();
    n_checks++;
    if (status_data !== 32'h0002_0109) begin
      n_fail++;
      $display("[TB] FAIL bad8: got %h expected %h", status_data, 32'h0002_0109);
    end
    send_frame(1, 1'b0);
    cycle();
    n_checks++;
    if (status_data !== 32'h0002_0209) begin
      n_fail++;
      $display("[TB] FAIL good1_runt: got %h expected %h", status_data, 32'h0002_0209);
    end
  endtask

  task automatic test_link_drop();
    apply_reset();
    rx_valid = 1'b1;
    rx_eof   = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if (status_data !== 32'h0000_0003) begin
      n_fail++;
      $display("[TB] FAIL in_frame_bit: got %h expected %h", status_data, 32'h0000_0003);
    end
    link_up = 1'b0;
    cycle();
    rx_valid = 1'b0;
    cycle();
    n_checks++;
    if (status_data !== 32'h0001_0008) begin
      n_fail++;
      $display("[TB] FAIL link_abort: got %h expected %h", status_data, 32'h0001_0008);
    end
    send_frame(1, 1'b1);
    cycle();
    n_checks++;
    if (status_data !== 32'h0001_0008) begin
      n_fail++;
      $display("[TB] FAIL link_down_ignore: got %h expected %h", status_data, 32'h0001_0008);
    end
    link_up = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (status_data !== 32'h0001_0009) begin
      n_fail++;
      $display("[TB] FAIL link_restore: got %h expected %h", status_data, 32'h0001_0009);
    end
  endtask

  task automatic test_clr_same_cycle();
    apply_reset();
    send_frame(1, 1'b1);
    send_frame(1, 1'b1);
    rx_overrun = 1'b1;
    cycle();
    rx_overrun = 1'b0;
    cycle();
    n_checks++;
    if (status_data !== 32'h0002_020D) begin
      n_fail++;
      $display("[TB] FAIL pre_clear: got %h expected %h", status_data, 32'h0002_020D);
    end
    ctrl_clr = 1'b1;
    send_frame(1, 1'b1);
    cycle();
    n_checks++;
    if (status_data !== 32'h0001_0109) begin
      n_fail++;
      $display("[TB] FAIL clr_with_bad_eof: got %h expected %h", status_data, 32'h0001_0109);
    end
    ctrl_clr = 1'b0;
  endtask

  task automatic test_clr_held();
    apply_reset();
    send_frame(1, 1'b1);
    send_frame(1, 1'b1);
    ctrl_clr   = 1'b1;
    rx_overrun = 1'b1;
    cycle();
    rx_overrun = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (i == 4 || i == 6) begin
        send_frame(1, 1'b1);
      end else begin
        cycle();
      end
    end
    ctrl_clr = 1'b0;
    cycle();
    cycle();
    n_checks++;
    if (status_data !== 32'h0002_020D) begin
      n_fail++;
      $display("[TB] FAIL clr_held_once: got %h expected %h", status_data, 32'h0002_020D);
    end
  endtask

  task automatic test_rst_mid_frame();
    apply_reset();
    send_frame(1, 1'b1);
    rx_valid = 1'b1;
    rx_eof   = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    rx_valid = 1'b0;
    user_rst = 1'b1;
    cycle();
    user_rst = 1'b0;
    n_checks++;
    if (status_data !== 32'h0000_0000) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_value: got %h expected %h", status_data, 32'h0000_0000);
    end
    send_frame(2, 1'b0);
    cycle();
    n_checks++;
    if (status_data !== 32'h0000_0101) begin
      n_fail++;
      $display("[TB] FAIL after_mid_reset: got %h expected %h", status_data, 32'h0000_0101);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    rx_valid = 1'b1;
    rx_eof   = 1'b1;
    rx_bad   = 1'b1;
    for (int i = 0; i < 300; i++) cycle();
    rx_valid = 1'b0;
    cycle();
    n_checks++;
    if (status_data !== 32'h012C_FF09) begin
      n_fail++;
      $display("[TB] FAIL runt_saturate: got %h expected %h", status_data, 32'h012C_FF09);
    end
    rx_valid = 1'b1;
    for (int i = 0; i < 69700; i++) cycle();
    rx_valid = 1'b0;
    rx_eof   = 1'b0;
    rx_bad   = 1'b0;
    cycle();
    n_checks++;
    if (status_data !== 32'hFFFF_FF09) begin
      n_fail++;
      $display("[TB] FAIL bad_saturate: got %h expected %h", status_data, 32'hFFFF_FF09);
    end
  endtask

  // Run every scenario in sequence, then report
  initial begin
    user_rst   = 1'b1;
    rx_valid   = 1'b0;
    rx_eof     = 1'b0;
    rx_bad     = 1'b0;
    rx_overrun = 1'b0;
    link_up    = 1'b1;
    ctrl_clr   = 1'b0;
    test_reset();
    test_clean_frame();
    test_bad_runt();
    test_link_drop();
    test_clr_same_cycle();
    test_clr_held();
    test_rst_mid_frame();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
